// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-ported data memory: combinational grant,
// round-robin on ties with a bounded lock, registered per-master read return.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    logic             last_gnt;
    logic             owner_locked;
    logic             owner;
    logic [CNT_W-1:0] hold_cnt;

    logic              req0, req1;
    logic              any_gnt, win;
    logic              g_we, g_lock;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // Requests are masked while reset is asserted so no access leaks out mid-reset.
    assign req0 = m0_req & rst_n;
    assign req1 = m1_req & rst_n;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (req0 && !req1) begin
            m0_gnt = 1'b1;
        end else if (req1 && !req0) begin
            m1_gnt = 1'b1;
        end else if (req0 && req1) begin
            if (owner_locked && (hold_cnt < HOLD_MAX)) begin
                m0_gnt = ~owner;
                m1_gnt = owner;
            end else begin
                m0_gnt = last_gnt;
                m1_gnt = ~last_gnt;
            end
        end
    end

    assign any_gnt = m0_gnt | m1_gnt;
    assign win     = m1_gnt;
    assign g_we    = win ? m1_we    : m0_we;
    assign g_lock  = win ? m1_lock  : m0_lock;
    assign g_addr  = win ? m1_addr  : m0_addr;
    assign g_wdata = win ? m1_wdata : m0_wdata;

    assign mem_write      = any_gnt & g_we;
    assign mem_read       = any_gnt & ~g_we;
    assign mem_address    = any_gnt ? g_addr  : '0;
    assign mem_write_data = any_gnt ? g_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt     <= 1'b1;
            owner_locked <= 1'b0;
            owner        <= 1'b0;
            hold_cnt     <= '0;
        end else if (any_gnt) begin
            last_gnt <= win;
            if (g_lock) begin
                owner        <= win;
                owner_locked <= 1'b1;
                if (owner_locked && (owner == win)) begin
                    if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end else begin
                    hold_cnt <= CNT_W'(1);
                end
            end else begin
                owner_locked <= 1'b0;
                hold_cnt     <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= mem_read_data;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus reset sequences,
// with a small word memory behind the arbiter.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Word memory: unwritten words read as 0xA000_000n for word index n.
    logic [31:0] mem [16];
    logic [15:0] written;
    logic [3:0]  idx;
    assign idx = mem_address[5:2];
    assign mem_read_data = written[idx] ? mem[idx] : (32'hA000_0000 | {28'h0, idx});

    always @(posedge clk) begin
        if (!rst_n) begin
            written <= '0;
        end else if (mem_write) begin
            mem[idx]     <= mem_write_data;
            written[idx] <= 1'b1;
        end
    end

    // c0/c1 = {req, we, lock}; ex = {gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1};
    // rc = {check rdata0, check rdata1}
    typedef struct {
        logic [2:0]  c0;
        logic [31:0] a0, d0;
        logic [2:0]  c1;
        logic [31:0] a1, d1;
        logic [5:0]  ex;
        logic [31:0] ma, mwd;
        logic [1:0]  rc;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vq[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {m0_req, m0_we, m0_lock} = v.c0;
        m0_addr = v.a0;
        m0_wdata = v.d0;
        {m1_req, m1_we, m1_lock} = v.c1;
        m1_addr = v.a1;
        m1_wdata = v.d1;
    endtask

    task automatic idle_inputs();
        {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
        m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    initial begin
        // Single requester write then read, idle masking
        vq.push_back('{3'b000, 0, 0, 3'b000, 0, 0, 6'b000000, 0, 0, 2'b00, 0, 0});
        vq.push_back('{3'b000, 0, 0, 3'b110, 'h10, 'hDEADBEEF, 6'b010100, 'h10, 'hDEADBEEF, 2'b00, 0, 0});
        vq.push_back('{3'b000, 0, 0, 3'b100, 'h10, 0, 6'b011000, 'h10, 0, 2'b00, 0, 0});
        vq.push_back('{3'b000, 0, 0, 3'b000, 0, 0, 6'b000001, 0, 0, 2'b01, 0, 'hDEADBEEF});
        vq.push_back('{3'b000, 'h3C, 'hFFFF, 3'b010, 'h20, 1, 6'b000000, 0, 0, 2'b01, 0, 'hDEADBEEF});
        // Contention without lock: alternate m0, m1, m0, m1
        vq.push_back('{3'b100, 0, 0, 3'b100, 4, 0, 6'b101000, 0, 0, 2'b00, 0, 0});
        vq.push_back('{3'b100, 0, 0, 3'b100, 4, 0, 6'b011010, 4, 0, 2'b10, 'hA0000000, 0});
        vq.push_back('{3'b100, 0, 0, 3'b100, 4, 0, 6'b101001, 0, 0, 2'b01, 0, 'hA0000001});
        vq.push_back('{3'b100, 0, 0, 3'b100, 4, 0, 6'b011010, 4, 0, 2'b10, 'hA0000000, 0});
        vq.push_back('{3'b000, 0, 0, 3'b000, 0, 0, 6'b000001, 0, 0, 2'b01, 0, 'hA0000001});
        // Read by m0 then write by m1 to the same word: read sees old value
        vq.push_back('{3'b100, 8, 0, 3'b000, 0, 0, 6'b101000, 8, 0, 2'b00, 0, 0});
        vq.push_back('{3'b000, 0, 0, 3'b110, 8, 'h12345678, 6'b010110, 8, 'h12345678, 2'b10, 'hA0000002, 0});
        vq.push_back('{3'b100, 8, 0, 3'b000, 0, 0, 6'b101000, 8, 0, 2'b00, 0, 0});
        vq.push_back('{3'b000, 0, 0, 3'b000, 0, 0, 6'b000010, 0, 0, 2'b10, 'h12345678, 0});
        // Lock with MAX_HOLD=4: m0 x4, forced hand-over to m1, then m0
        vq.push_back('{3'b000, 0, 0, 3'b100, 4, 0, 6'b011000, 4, 0, 2'b00, 0, 0});
        vq.push_back('{3'b101, 0, 0, 3'b100, 4, 0, 6'b101001, 0, 0, 2'b01, 0, 'hA0000001});
        vq.push_back('{3'b101, 0, 0, 3'b100, 4, 0, 6'b101010, 0, 0, 2'b10, 'hA0000000, 0});
        vq.push_back('{3'b101, 0, 0, 3'b100, 4, 0, 6'b101010, 0, 0, 2'b10, 'hA0000000, 0});
        vq.push_back('{3'b101, 0, 0, 3'b100, 4, 0, 6'b101010, 0, 0, 2'b10, 'hA0000000, 0});
        vq.push_back('{3'b101, 0, 0, 3'b100, 4, 0, 6'b011010, 4, 0, 2'b10, 'hA0000000, 0});
        vq.push_back('{3'b101, 0, 0, 3'b100, 4, 0, 6'b101001, 0, 0, 2'b01, 0, 'hA0000001});
        // Lock dropped on m0's second grant: m1 wins next
        vq.push_back('{3'b100, 0, 0, 3'b100, 4, 0, 6'b101010, 0, 0, 2'b10, 'hA0000000, 0});
        vq.push_back('{3'b101, 0, 0, 3'b100, 4, 0, 6'b011010, 4, 0, 2'b10, 'hA0000000, 0});
        // m1 takes lock then goes idle: m0 is not stalled
        vq.push_back('{3'b000, 0, 0, 3'b101, 4, 0, 6'b011001, 4, 0, 2'b01, 0, 'hA0000001});
        vq.push_back('{3'b110, 'hC, 'h55, 3'b000, 0, 0, 6'b100101, 'hC, 'h55, 2'b01, 0, 'hA0000001});
        vq.push_back('{3'b100, 'hC, 0, 3'b000, 0, 0, 6'b101000, 'hC, 0, 2'b00, 0, 0});

        rst_n = 1'b0;
        idle_inputs();
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        chk1("rst gnt0", m0_gnt, 1'b0);
        chk1("rst gnt1", m1_gnt, 1'b0);
        chk1("rst mem_read", mem_read, 1'b0);
        chk1("rst mem_write", mem_write, 1'b0);
        chk32("rst mem_address", mem_address, 32'h0);
        chk32("rst mem_write_data", mem_write_data, 32'h0);
        chk1("rst rvalid0", m0_rvalid, 1'b0);
        chk1("rst rvalid1", m1_rvalid, 1'b0);
        chk32("rst rdata0", m0_rdata, 32'h0);
        chk32("rst rdata1", m1_rdata, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk1($sformatf("r%0d gnt0", i), m0_gnt, vq[i].ex[5]);
            chk1($sformatf("r%0d gnt1", i), m1_gnt, vq[i].ex[4]);
            chk1($sformatf("r%0d mem_read", i), mem_read, vq[i].ex[3]);
            chk1($sformatf("r%0d mem_write", i), mem_write, vq[i].ex[2]);
            chk32($sformatf("r%0d mem_address", i), mem_address, vq[i].ma);
            chk32($sformatf("r%0d mem_write_data", i), mem_write_data, vq[i].mwd);
            chk1($sformatf("r%0d rvalid0", i), m0_rvalid, vq[i].ex[1]);
            chk1($sformatf("r%0d rvalid1", i), m1_rvalid, vq[i].ex[0]);
            if (vq[i].rc[1]) chk32($sformatf("r%0d rdata0", i), m0_rdata, vq[i].rd0);
            if (vq[i].rc[0]) chk32($sformatf("r%0d rdata1", i), m1_rdata, vq[i].rd1);
        end

        // Reset asserted in the middle of an m0 read grant
        @(negedge clk);
        idle_inputs();
        m0_req = 1'b1;
        #1;
        chk1("pre-rst rvalid0", m0_rvalid, 1'b1);
        chk32("pre-rst rdata0", m0_rdata, 32'h55);
        chk1("pre-rst gnt0", m0_gnt, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("mid-rst gnt0", m0_gnt, 1'b0);
        chk1("mid-rst mem_read", mem_read, 1'b0);
        chk32("mid-rst mem_address", mem_address, 32'h0);
        chk1("mid-rst rvalid0", m0_rvalid, 1'b0);
        chk32("mid-rst rdata0", m0_rdata, 32'h0);
        chk32("mid-rst rdata1", m1_rdata, 32'h0);
        @(negedge clk);
        #1;
        chk1("post-edge rvalid0", m0_rvalid, 1'b0);
        chk1("post-edge mem_read", mem_read, 1'b0);
        rst_n = 1'b1;
        m1_req = 1'b1;
        m1_addr = 32'h4;
        #1;
        chk1("tie after rst gnt0", m0_gnt, 1'b1);
        chk1("tie after rst gnt1", m1_gnt, 1'b0);
        chk1("tie after rst mem_read", mem_read, 1'b1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk1("tie after rst rvalid0", m0_rvalid, 1'b1);
        chk1("tie after rst rvalid1", m1_rvalid, 1'b0);
        chk32("tie after rst rdata0", m0_rdata, 32'hA0000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
